// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back path: geometry,
// the hard-wired zero register and the fixed requester slots.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREQ   = 2;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle shared by all requesters.
// master = requester side (drives valid/addr/data), slave = arbiter side (drives ready).
interface regfile_wb_arbiter_if #(
    parameter int NREQ   = regfile_pkg::NREQ,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin pick: first valid at or after ptr_i, wrapping.
// Ports: valid_i, ptr_i in; one-hot grant_o and its index gidx_o out.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] gidx_o
);

    always_comb begin
        logic found;
        int   idx;
        grant_o = '0;
        gidx_o  = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && valid_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                gidx_o       = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NREQ requesters (round-robin)
// and keeps a busy scoreboard of claimed-but-unwritten destinations.
// Ports: clk, rst; wb (request bundle, slave); claim_valid/claim_addr;
// chk_a1/chk_a2 -> stall; busy; we3/A3/WD3 to the register file.
module regfile_wb_arbiter #(
    parameter int NREQ   = regfile_pkg::NREQ,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 claim_valid,
    input  logic [ADDR_W-1:0]    claim_addr,
    input  logic [ADDR_W-1:0]    chk_a1,
    input  logic [ADDR_W-1:0]    chk_a2,
    output logic                 stall,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 we3,
    output logic [ADDR_W-1:0]    A3,
    output logic [DATA_W-1:0]    WD3
);

    import regfile_pkg::REG_ZERO;

    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREGS = 2**ADDR_W;

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   grant;
    logic [PW-1:0]     gidx;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              we3_q;
    logic [ADDR_W-1:0] a3_q;
    logic [DATA_W-1:0] wd3_q;
    logic [NREGS-1:0]  busy_q, busy_d;

    rr_arbiter #(.N(NREQ), .IW(PW)) u_rr (
        .valid_i (wb.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .gidx_o  (gidx)
    );

    // No grant may be seen while reset is held, even with valids up.
    assign wb.req_ready = rst ? '0 : grant;
    assign xfer         = |(wb.req_valid & wb.req_ready);

    assign sel_addr = wb.req_addr[int'(gidx)*ADDR_W +: ADDR_W];
    assign sel_data = wb.req_data[int'(gidx)*DATA_W +: DATA_W];

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        end
    end

    // Clear first, then set: a claim landing on the register being
    // retired this edge belongs to a newer instruction and must survive.
    always_comb begin
        busy_d = busy_q;
        if (we3_q) begin
            busy_d[a3_q] = 1'b0;
        end
        if (claim_valid && claim_addr != REG_ZERO) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            we3_q  <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            busy_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            if (xfer) begin
                // $zero writes are accepted but never enabled.
                we3_q <= (sel_addr != REG_ZERO);
                a3_q  <= sel_addr;
                wd3_q <= sel_data;
            end else begin
                we3_q <= 1'b0;
            end
        end
    end

    assign we3   = we3_q;
    assign A3    = a3_q;
    assign WD3   = wd3_q;
    assign busy  = busy_q;
    assign stall = busy_q[chk_a1] | busy_q[chk_a2];

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and hazard scoreboard for the 32×32 MIPS register file. It shares the register file's single write port (we3/A3/WD3) among NREQ write-back requesters with round-robin fairness. It tracks destination registers that have been claimed but not yet written, so the controller can stall operand reads that would return stale data. It sits between the execute/memory stages and the register file and drives its write port directly.

## Interface
- NREQ, 2, number of write-back requesters (2..4)
- DATA_W, 32, register width
- ADDR_W, 5, register index width; scoreboard has 2**ADDR_W bits

- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*ADDR_W  destination index, slice i = bits [i*ADDR_W +: ADDR_W]
- req_data  in  NREQ*DATA_W  write data, slice i likewise
- req_ready  out  NREQ  one-hot grant; transfer on valid&ready
- claim_valid  in  1  issuing instruction reserves a destination
- claim_addr  in  ADDR_W  reserved destination index
- chk_a1, chk_a2  in  ADDR_W  operand indices about to be read (A1/A2)
- stall  out  1  busy[chk_a1] | busy[chk_a2]
- busy  out  2**ADDR_W  scoreboard, bit r = register r has a write outstanding
- we3  out  1  register file write enable
- A3  out  ADDR_W  register file write index
- WD3  out  DATA_W  register file write data

## Operation
- Round-robin pointer ptr (0..NREQ-1). Winner = first i with req_valid[i], searching ptr, ptr+1, … mod NREQ.
- req_ready is combinational. It is one-hot on the winner and all-zero when no valid is asserted or while rst=1.
- Requesters hold valid/addr/data stable until ready. Dropping valid without ready is illegal.
- On a transfer from i: ptr ← (i+1) mod NREQ. With no transfer, ptr is unchanged.
- Output stage is registered. After a transfer, we3←1, A3←addr, WD3←data. With no transfer, we3←0 and A3/WD3 hold their values.
- Writes to register 0 are still granted (ready=1), but we3 stays 0 so $zero is never written. A3/WD3 update anyway.
- Scoreboard, evaluated at each edge:
  - set: claim_valid and claim_addr≠0 → busy[claim_addr]←1
  - clear: we3=1 → busy[A3]←0
  - same index set and cleared in the same cycle → set wins (newer claim outstanding)
- busy[0] is constantly 0. A claim to 0 is ignored.
- stall is combinational from busy and chk_a*. It is 0 for index 0.
- Write to a register with busy=0 (unclaimed) is legal; it is simply written.

## Timing
- Reset values: we3=0, A3=0, WD3=0, busy=0, ptr=0, req_ready=0, stall=0.
- rst asserted mid-operation: a pending we3 is dropped immediately (asynchronous); the scoreboard is cleared.
- Grant in cycle N → we3=1 in N+1 → register file commits and busy bit clears at the end of N+1.
- A synchronous read issued in N+2 returns new data with stall=0.
- Throughput: one write per cycle, back-to-back, across any mix of requesters.
- All NREQ valid continuously: each requester granted exactly once every NREQ cycles.
- Claim in cycle N → busy/stall visible in N+1.

## Structure
- Shared package regfile_pkg: ADDR_W, DATA_W, REG_ZERO (=0), NREQ default, requester index constants (REQ_ALU=0, REQ_MEM=1).
- One sub-module: rr_arbiter. Parameter N; inputs valid[N], ptr; outputs one-hot grant and grant index. Purely combinational.
- Pointer, output register and scoreboard live in regfile_wb_arbiter.

## Test plan
- Reset, then single write: req_valid=01, addr=8, data=0x1234 → ready=01 same cycle; next cycle we3=1, A3=8, WD3=0x1234; then we3=0.
- Fairness: both valid every cycle for 6 cycles → grants alternate 01,10,01,10,01,10; we3=1 all 6 following cycles.
- $zero: req addr=0, data=0xFFFFFFFF → ready=1; we3 stays 0; busy all 0.
- Scoreboard: claim 9 in N → busy[9]=1 and stall=1 with chk_a1=9 from N+1. Write 9 granted in M → busy[9]=0 at M+2.
- Same-edge collision: we3=1 with A3=5 while claim_addr=5 → busy[5] remains 1.
- Async reset while we3=1 and busy[3]=1 → we3=0 and busy=0 immediately, without waiting for clk. After release, ptr=0 (requester 0 wins a tie).
